// File: rtl/rxhexword.sv
// rxhexword: 8N1 UART receiver plus a line parser for "0x" + 8 hex digits + [CR] LF.
//
// Ports:
//   i_clk      system clock, all logic on posedge
//   i_reset_n  asynchronous active-low reset
//   i_uart_rx  raw serial input, idle high, asynchronous to i_clk
//   o_stb      one-cycle pulse, o_data holds a newly decoded word
//   o_data     last successfully decoded 32-bit word
//   o_err      one-cycle pulse on a framing error or a malformed line
module rxhexword #(
    parameter int CLOCKS_PER_BAUD = 868
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_uart_rx,
    output logic        o_stb,
    output logic [31:0] o_data,
    output logic        o_err
);

    localparam logic [23:0] HALF_BAUD = 24'(CLOCKS_PER_BAUD / 2 - 1);
    localparam logic [23:0] FULL_BAUD = 24'(CLOCKS_PER_BAUD - 1);

    localparam logic [2:0] RX_WAITIDLE = 3'd0;
    localparam logic [2:0] RX_IDLE     = 3'd1;
    localparam logic [2:0] RX_START    = 3'd2;
    localparam logic [2:0] RX_DATA     = 3'd3;
    localparam logic [2:0] RX_STOP     = 3'd4;

    localparam logic [2:0] P_ZERO = 3'd0;
    localparam logic [2:0] P_X    = 3'd1;
    localparam logic [2:0] P_DIG  = 3'd2;
    localparam logic [2:0] P_END  = 3'd3;
    localparam logic [2:0] P_LF   = 3'd4;

    // ---------------- input synchroniser ----------------
    logic rx_meta, rx_sync;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_uart_rx;
            rx_sync <= rx_meta;
        end
    end

    // ---------------- UART receiver ----------------
    logic [2:0]  rx_state;
    logic [23:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  rx_byte;
    logic        byte_vld;
    logic        frame_err;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rx_state  <= RX_WAITIDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            rx_byte   <= '0;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
            case (rx_state)
                RX_WAITIDLE: if (rx_sync) rx_state <= RX_IDLE;
                RX_IDLE: if (!rx_sync) begin
                    baud_cnt <= HALF_BAUD;
                    rx_state <= RX_START;
                end
                RX_START: begin
                    if (baud_cnt == 24'd0) begin
                        // Re-check mid start bit; a short glitch lands back in idle.
                        if (!rx_sync) begin
                            baud_cnt <= FULL_BAUD;
                            bit_cnt  <= 3'd0;
                            rx_state <= RX_DATA;
                        end else begin
                            rx_state <= RX_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 24'd1;
                    end
                end
                RX_DATA: begin
                    if (baud_cnt == 24'd0) begin
                        rx_byte  <= {rx_sync, rx_byte[7:1]};
                        baud_cnt <= FULL_BAUD;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        baud_cnt <= baud_cnt - 24'd1;
                    end
                end
                RX_STOP: begin
                    if (baud_cnt == 24'd0) begin
                        if (rx_sync) begin
                            byte_vld <= 1'b1;
                            rx_state <= RX_IDLE;
                        end else begin
                            // Wait for a high line so a break cannot retrigger.
                            frame_err <= 1'b1;
                            rx_state  <= RX_WAITIDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 24'd1;
                    end
                end
                default: rx_state <= RX_WAITIDLE;
            endcase
        end
    end

    // ---------------- hex decode ----------------
    logic       is_hex;
    logic [3:0] nibble;

    always_comb begin
        is_hex = 1'b0;
        nibble = 4'd0;
        if (rx_byte >= 8'h30 && rx_byte <= 8'h39) begin
            is_hex = 1'b1;
            nibble = 4'(rx_byte - 8'h30);
        end else if (rx_byte >= 8'h61 && rx_byte <= 8'h66) begin
            is_hex = 1'b1;
            nibble = 4'(rx_byte - 8'h57);
        end else if (rx_byte >= 8'h41 && rx_byte <= 8'h46) begin
            is_hex = 1'b1;
            nibble = 4'(rx_byte - 8'h37);
        end
    end

    // ---------------- line parser ----------------
    logic [2:0]  p_state;
    logic [31:0] shift;
    logic [2:0]  dig_cnt;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            p_state <= P_ZERO;
            shift   <= '0;
            dig_cnt <= '0;
            o_stb   <= 1'b0;
            o_err   <= 1'b0;
            o_data  <= '0;
        end else begin
            o_stb <= 1'b0;
            o_err <= 1'b0;
            if (frame_err) begin
                o_err   <= 1'b1;
                p_state <= P_ZERO;
            end else if (byte_vld) begin
                case (p_state)
                    P_ZERO: if (rx_byte == 8'h30) p_state <= P_X;
                    P_X: begin
                        if (rx_byte == 8'h78 || rx_byte == 8'h58) begin
                            shift   <= '0;
                            dig_cnt <= '0;
                            p_state <= P_DIG;
                        end else begin
                            o_err   <= 1'b1;
                            p_state <= P_ZERO;
                        end
                    end
                    P_DIG: begin
                        if (is_hex) begin
                            shift   <= {shift[27:0], nibble};
                            dig_cnt <= dig_cnt + 3'd1;
                            if (dig_cnt == 3'd7) p_state <= P_END;
                        end else begin
                            o_err   <= 1'b1;
                            p_state <= P_ZERO;
                        end
                    end
                    P_END: begin
                        if (rx_byte == 8'h0d) begin
                            p_state <= P_LF;
                        end else if (rx_byte == 8'h0a) begin
                            o_data  <= shift;
                            o_stb   <= 1'b1;
                            p_state <= P_ZERO;
                        end else begin
                            o_err   <= 1'b1;
                            p_state <= P_ZERO;
                        end
                    end
                    P_LF: begin
                        if (rx_byte == 8'h0a) begin
                            o_data <= shift;
                            o_stb  <= 1'b1;
                        end else begin
                            o_err  <= 1'b1;
                        end
                        p_state <= P_ZERO;
                    end
                    default: p_state <= P_ZERO;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rxhexword.sv
// Scoreboard bench for rxhexword: stimulus pushes expected events, a monitor pops on o_stb/o_err.
module tb_rxhexword;

    localparam int CPB = 16;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_uart_rx = 1'b1;
    logic        o_stb;
    logic [31:0] o_data;
    logic        o_err;

    typedef struct {
        bit          err;
        logic [31:0] data;
    } ev_t;

    ev_t         exp_q[$];
    logic [31:0] last_data = '0;
    int          checks = 0;
    int          errors = 0;

    rxhexword #(.CLOCKS_PER_BAUD(CPB)) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_uart_rx (i_uart_rx),
        .o_stb     (o_stb),
        .o_data    (o_data),
        .o_err     (o_err)
    );

    always #5 i_clk = ~i_clk;

    // Monitor
    always @(negedge i_clk) begin
        if (i_reset_n && (o_stb || o_err)) begin
            checks++;
            if (o_stb && o_err) begin
                errors++;
                $display("FAIL excl: o_stb=%0b o_err=%0b both high", o_stb, o_err);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected: o_stb=%0b o_err=%0b o_data=%h, none expected", o_stb, o_err, o_data);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (o_err != e.err || o_data != e.data) begin
                    errors++;
                    $display("FAIL event: got err=%0b data=%h, expected err=%0b data=%h",
                             o_err, o_data, e.err, e.data);
                end
            end
        end
    end

    task automatic push_stb(input logic [31:0] d);
        ev_t e;
        e.err = 1'b0; e.data = d;
        last_data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        ev_t e;
        e.err = 1'b1; e.data = last_data;
        exp_q.push_back(e);
    endtask

    task automatic send_bit(input logic b);
        i_uart_rx = b;
        repeat (CPB) @(posedge i_clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic idle_check(input string name);
        i_uart_rx = 1'b1;
        repeat (4 * CPB) @(posedge i_clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected events outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        repeat (5) @(posedge i_clk);
        #1;
        checks += 3;
        if (o_stb !== 1'b0) begin errors++; $display("FAIL rst_stb: got %b, required 0", o_stb); end
        if (o_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b, required 0", o_err); end
        if (o_data !== 32'h0) begin errors++; $display("FAIL rst_data: got %h, required 0", o_data); end
        @(negedge i_clk);
        i_reset_n = 1'b1;
        repeat (3 * CPB) @(posedge i_clk);

        // Basic CR LF line
        push_stb(32'h0000002A);
        send_str("0x0000002A"); send_byte(8'h0d); send_byte(8'h0a);
        idle_check("crlf");

        // Leading garbage, mixed case, LF only
        push_stb(32'hDEADBEEF);
        send_str("zz0xdeadBEEF"); send_byte(8'h0a);
        idle_check("garbage");

        // Bad digit, then recovery
        push_err();
        send_str("0x12G4");
        push_stb(32'h00000001);
        send_str("0x00000001"); send_byte(8'h0d); send_byte(8'h0a);
        idle_check("baddigit");

        // 9th digit in P_END
        push_err();
        send_str("0x123456789"); send_byte(8'h0a);
        idle_check("ninth");

        // Framing error: '0' parsed, then a dropped '0' with bad stop, line low 40 clocks.
        // Parser must be back in P_ZERO, so the following "x..." line is ignored.
        send_str("0");
        push_err();
        send_byte(8'h30, 1'b0);
        i_uart_rx = 1'b0;
        repeat (40) @(posedge i_clk);
        i_uart_rx = 1'b1;
        repeat (2 * CPB) @(posedge i_clk);
        send_str("x12345678"); send_byte(8'h0a);
        idle_check("frame");

        // Short glitch
        i_uart_rx = 1'b0;
        repeat (4) @(posedge i_clk);
        i_uart_rx = 1'b1;
        repeat (10 * CPB) @(posedge i_clk);
        idle_check("glitch");

        // Reset during the 5th digit
        send_str("0xCAFE");
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0 ^ logic'((8'h46 >> i) & 8'h01));
        i_reset_n = 1'b0;
        i_uart_rx = 1'b1;
        last_data = '0;
        repeat (3) @(posedge i_clk);
        #1;
        checks++;
        if (o_data !== 32'h0) begin errors++; $display("FAIL midrst_data: got %h, required 0", o_data); end
        @(negedge i_clk);
        i_reset_n = 1'b1;
        repeat (3 * CPB) @(posedge i_clk);
        push_stb(32'h00000007);
        send_str("0x00000007"); send_byte(8'h0a);
        idle_check("afterrst");

        checks++;
        if (o_data !== 32'h00000007) begin
            errors++;
            $display("FAIL hold_data: got %h, required 00000007", o_data);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
